// File: rtl/lcd_timing_gen.sv
// LCD panel timing generator: h/v counters, upstream pixel requests and a
// two-stage output pipeline driving DE, HS, VS and RGB565 colour.
module lcd_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 21,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] pix_data,
  output logic        data_req,
  output logic [10:0] pos_x,
  output logic [9:0]  pos_y,
  output logic        frame_start,
  output logic        lcd_de,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic [4:0]  lcd_r,
  output logic [5:0]  lcd_g,
  output logic [4:0]  lcd_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SB   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SB   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  logic          run;
  logic          req_d, fs_d, hs_d, vs_d;
  logic [10:0]   px_d;
  logic [9:0]    py_d;

  logic          req_q, fs_q, hs0_q, vs0_q;
  logic [10:0]   px_q;
  logic [9:0]    py_q;
  logic          req1_q, hs1_q, vs1_q;
  logic          de_q, hs2_q, vs2_q;
  logic [15:0]   rgb_q;

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    unique case (state_q)
      IDLE: begin
        if (en) state_d = RUN;
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
          h_d     = '0;
          v_d     = '0;
        end else if (h_q == H_LAST) begin
          h_d = '0;
          v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end else begin
          h_d = h_q + 1'b1;
        end
      end
    endcase
  end

  // Counter state is only meaningful once RUN has been entered with en held
  always_comb begin
    run   = (state_q == RUN) && en;
    req_d = run && (h_q < H_ACT) && (v_q < V_ACT);
    fs_d  = run && (h_q == '0) && (v_q == '0);
    hs_d  = (run && h_q >= H_SB && h_q < H_SE) ? HS_POL : ~HS_POL;
    vs_d  = (run && v_q >= V_SB && v_q < V_SE) ? VS_POL : ~VS_POL;
    px_d  = req_d ? 11'(h_q) : '0;
    py_d  = req_d ? 10'(v_q) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= 1'b0;
      fs_q  <= 1'b0;
      px_q  <= '0;
      py_q  <= '0;
      hs0_q <= ~HS_POL;
      vs0_q <= ~VS_POL;
    end else begin
      req_q <= req_d;
      fs_q  <= fs_d;
      px_q  <= px_d;
      py_q  <= py_d;
      hs0_q <= hs_d;
      vs0_q <= vs_d;
    end
  end

  // Dropping en flushes the in-flight pixels instead of letting them drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req1_q <= 1'b0;
      hs1_q  <= ~HS_POL;
      vs1_q  <= ~VS_POL;
      de_q   <= 1'b0;
      rgb_q  <= '0;
      hs2_q  <= ~HS_POL;
      vs2_q  <= ~VS_POL;
    end else if (!en) begin
      req1_q <= 1'b0;
      hs1_q  <= ~HS_POL;
      vs1_q  <= ~VS_POL;
      de_q   <= 1'b0;
      rgb_q  <= '0;
      hs2_q  <= ~HS_POL;
      vs2_q  <= ~VS_POL;
    end else begin
      req1_q <= req_q;
      hs1_q  <= hs0_q;
      vs1_q  <= vs0_q;
      de_q   <= req1_q;
      rgb_q  <= req1_q ? pix_data : '0;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
    end
  end

  assign data_req    = req_q;
  assign pos_x       = px_q;
  assign pos_y       = py_q;
  assign frame_start = fs_q;
  assign lcd_de      = de_q;
  assign lcd_hs      = hs2_q;
  assign lcd_vs      = vs2_q;
  assign lcd_r       = rgb_q[15:11];
  assign lcd_g       = rgb_q[10:5];
  assign lcd_b       = rgb_q[4:0];

endmodule
